inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, 8, entry count; power of two, >= 2*FETCH_W.
REQ-002 SHALL have parameter FETCH_W, 2, input lanes per cycle.
REQ-003 SHALL have parameter ISSUE_W, 2, output lanes per cycle; ISSUE_W <= DEPTH.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous clear (branch redirect).
REQ-007 SHALL have port stop  input  1  when high, no entries are written this cycle.
REQ-008 SHALL have port in_valid  input  FETCH_W  per-lane receive flag.
REQ-009 SHALL have port in_inst/in_pc/in_npc  input  FETCH_W*32 each  lane k at bits [32k+31:32k].
REQ-010 SHALL have port out_valid  output  ISSUE_W  lane k holds an entry.
REQ-011 SHALL have port out_inst/out_pc/out_npc  output  ISSUE_W*32 each  lane k = k-th oldest entry.
REQ-012 SHALL have port launch  input  ISSUE_W  per-lane consume from decode.
REQ-013 SHALL have port full  output  1  free slots < FETCH_W.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port error  output  1  sticky protocol-violation flag.

Function
REQ-016 SHALL be a circular queue: head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-017 SHALL compact valid input lanes: lanes with in_valid set are written in ascending lane order into consecutive slots from tail; invalid lanes occupy no slot (in_valid=2'b10 writes lane 1 only).
REQ-018 SHALL make written entries visible on out_* the cycle after the write edge; no input-to-output bypass.
REQ-019 SHALL drive out_valid[k] = (count > k); out_* lane k from slot (head+k) mod DEPTH; out_* contents don't-care when out_valid[k]=0.
REQ-020 SHALL pop P = number of launch bits set; launch must be a prefix (launch[k] implies launch[k-1]) and launch[k] implies out_valid[k].
REQ-021 SHALL, per edge, update count = count - P + W, W = written entries, pop and write permitted in the same cycle.
REQ-022 SHALL assert full combinationally when DEPTH - count < FETCH_W, evaluated before same-cycle launches.
REQ-023 SHALL drop the whole write and set error when valid lanes are offered with stop low while full=1.
REQ-024 SHALL ignore launch and set error for a non-prefix launch or a launch on a lane with out_valid=0; no pop occurs that cycle.
REQ-025 SHALL, on flush, set head=tail=0, count=0, out_valid=0 next cycle; same-cycle writes and launches discarded; flush takes priority over stop, writes and launches; error not cleared.
REQ-026 SHALL ignore in_* entirely while stop=1; launches still proceed.
REQ-027 SHALL keep error set once asserted until rst.

Reset
REQ-028 SHALL, on rst high, immediately (asynchronously) set head=0, tail=0, count=0, out_valid=0, full=0, error=0.
REQ-029 SHALL abandon any in-flight write or pop when rst asserts mid-cycle; first write accepted on the first rising edge after rst deasserts.
REQ-030 SHALL not reset entry storage contents; validity derives only from count.

Structure
REQ-031 SHALL take INST_W (32), PC_W (32), entry field layout {inst,pc,npc} and VALID from the shared def.vh definitions; no local redefinition.
REQ-032 SHALL place lane compaction (in_valid to per-slot write index and write count) in one sub-module iq_compact, parametrised by FETCH_W.
REQ-033 SHALL keep storage, pointers and count in inst_queue; no other sub-modules.

Verification
REQ-034 SHALL cover reset then in_valid=2'b11 (pc 0x100, 0x104) -> next cycle out_valid=2'b11, out_pc lane0=0x100, lane1=0x104, count=2.
REQ-035 SHALL cover in_valid=2'b10 with pc lane1=0x208 into empty queue -> out_valid=2'b01, out_pc lane0=0x208, count=1.
REQ-036 SHALL cover DEPTH=8 filled to 7 with launch=0 -> full=1; write 2'b11 -> dropped, error=1, count stays 7; then launch=2'b11 -> count=5, full=0, error stays 1.
REQ-037 SHALL cover wrap: 20 cycles of write 2'b11 and launch 2'b11 from count=2 -> out_pc sequence strictly +8 per cycle, count constant 2, error=0.
REQ-038 SHALL cover flush with count=6, in_valid=2'b11, launch=2'b11 same cycle -> next cycle count=0, out_valid=0; following write 2'b11 lands at head, count=2.
REQ-039 SHALL cover launch=2'b10 with count=3 -> error=1, count stays 3; rst pulse mid-run -> count=0, error=0 without a clock edge.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared entry layout and widths for the instruction queue.
// Fields are packed {inst, pc, npc}; VALID is the active level of per-lane flags.
package inst_queue_pkg;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam logic VALID = 1'b1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   npc;
  } entry_t;
endpackage

// File: rtl/inst_queue_compact.sv
// Lane compaction: slot offset of each valid fetch lane from tail, plus total write count.
// Purely combinational; no flow control of its own.
module iq_compact
  import inst_queue_pkg::*;
#(
  parameter int FETCH_W = 2,
  localparam int CW = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W-1:0]         in_valid,
  output logic [FETCH_W-1:0][CW-1:0] lane_off,
  output logic [CW-1:0]              wr_cnt
);

  logic [CW-1:0] acc;

  always_comb begin
    acc      = '0;
    lane_off = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      lane_off[k] = acc;
      if (in_valid[k] == VALID) acc = acc + CW'(1);
    end
    wr_cnt = acc;
  end

endmodule

// File: rtl/inst_queue.sv
// Circular fetch-to-decode instruction queue; writes visible one cycle after the write edge.
// Writes offered while full are dropped and flagged; decode pops a prefix of out lanes via launch.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        stop,
  input  logic [FETCH_W-1:0]          in_valid,
  input  logic [FETCH_W*INST_W-1:0]   in_inst,
  input  logic [FETCH_W*PC_W-1:0]     in_pc,
  input  logic [FETCH_W*PC_W-1:0]     in_npc,
  output logic [ISSUE_W-1:0]          out_valid,
  output logic [ISSUE_W*INST_W-1:0]   out_inst,
  output logic [ISSUE_W*PC_W-1:0]     out_pc,
  output logic [ISSUE_W*PC_W-1:0]     out_npc,
  input  logic [ISSUE_W-1:0]          launch,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        error
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(FETCH_W + 1);
  localparam int LW   = $clog2(ISSUE_W + 1);

  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            error_q, error_d;

  entry_t slot_mem [DEPTH];

  logic [FETCH_W-1:0][CW-1:0] lane_off;
  logic [CW-1:0]              wr_cnt;
  logic                       wr_ok, wr_err;
  logic [LW-1:0]              pop_cnt;
  logic [ISSUE_W-1:0]         pop_mask;
  logic                       launch_ok;

  iq_compact #(.FETCH_W(FETCH_W)) u_compact (
    .in_valid (in_valid),
    .lane_off (lane_off),
    .wr_cnt   (wr_cnt)
  );

  // Full is judged on the registered count, before any same-cycle pop frees space.
  assign full   = (CNTW'(DEPTH) - count_q) < CNTW'(FETCH_W);
  assign wr_ok  = !stop && (|in_valid) && !full;
  assign wr_err = !stop && (|in_valid) && full;
  assign count  = count_q;
  assign error  = error_q;

  always_comb begin
    pop_cnt  = '0;
    pop_mask = '0;
    for (int k = 0; k < ISSUE_W; k++)
      if (launch[k]) pop_cnt = pop_cnt + LW'(1);
    for (int k = 0; k < ISSUE_W; k++)
      if (LW'(k) < pop_cnt) pop_mask[k] = 1'b1;
    launch_ok = (launch == pop_mask) && ((launch & ~out_valid) == '0);
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    out_npc   = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      out_valid[k]                  = count_q > CNTW'(k);
      out_inst[k*INST_W +: INST_W]  = slot_mem[head_q + PW'(k)].inst;
      out_pc[k*PC_W +: PC_W]        = slot_mem[head_q + PW'(k)].pc;
      out_npc[k*PC_W +: PC_W]       = slot_mem[head_q + PW'(k)].npc;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    error_d = error_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok)     tail_d = tail_q + PW'(wr_cnt);
      if (launch_ok) head_d = head_q + PW'(pop_cnt);
      count_d = count_q + (wr_ok ? CNTW'(wr_cnt) : CNTW'(0))
                        - (launch_ok ? CNTW'(pop_cnt) : CNTW'(0));
      if (wr_err || !launch_ok) error_d = 1'b1;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush && !rst) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (in_valid[k] == VALID)
          slot_mem[tail_q + PW'(lane_off[k])] <= '{inst: in_inst[k*INST_W +: INST_W],
                                                   pc:   in_pc[k*PC_W +: PC_W],
                                                   npc:  in_npc[k*PC_W +: PC_W]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=8, FETCH_W=2, ISSUE_W=2) with hand-computed expectations.
module tb_inst_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [63:0] in_inst = '0, in_pc = '0, in_npc = '0;
  logic [1:0]  out_valid;
  logic [63:0] out_inst, out_pc, out_npc;
  logic [1:0]  launch = '0;
  logic        full;
  logic [3:0]  count;
  logic        error;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] nxt_pc;
  logic [31:0] exp_pc;

  inst_queue #(.DEPTH(8), .FETCH_W(2), .ISSUE_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stop(stop),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_npc(in_npc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_npc(out_npc),
    .launch(launch), .full(full), .count(count), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    in_valid = v;
    in_pc    = {p1, p0};
    in_npc   = {p1 + 32'd4, p0 + 32'd4};
    in_inst  = {~p1, ~p0};
  endtask

  task automatic idle();
    in_valid = '0;
    launch   = '0;
    flush    = 1'b0;
    stop     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rst_pulse(input string tag);
    rst = 1'b1;
    #2;
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_full"}, 64'(full), 64'd0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    rst = 1'b0;

    // two lanes into an empty queue
    drive(2'b11, 32'h100, 32'h104);
    step();
    chk("two_out_valid", 64'(out_valid), 64'h3);
    chk("two_pc0", 64'(out_pc[31:0]), 64'h100);
    chk("two_pc1", 64'(out_pc[63:32]), 64'h104);
    chk("two_inst0", 64'(out_inst[31:0]), 64'hffff_feff);
    chk("two_npc1", 64'(out_npc[63:32]), 64'h108);
    chk("two_count", 64'(count), 64'd2);

    flush = 1'b1;
    step();
    chk("flush1_count", 64'(count), 64'd0);

    // only lane 1 valid is compacted to the head slot
    drive(2'b10, 32'h200, 32'h208);
    step();
    chk("lane1_out_valid", 64'(out_valid), 64'h1);
    chk("lane1_pc0", 64'(out_pc[31:0]), 64'h208);
    chk("lane1_count", 64'(count), 64'd1);

    // stop ignores inputs, launch still pops
    stop = 1'b1;
    drive(2'b11, 32'hbad0, 32'hbad4);
    launch = 2'b01;
    step();
    chk("stop_count", 64'(count), 64'd0);
    chk("stop_error", 64'(error), 64'd0);

    // fill to 7 and overflow
    drive(2'b11, 32'h300, 32'h304); step();
    drive(2'b11, 32'h308, 32'h30c); step();
    drive(2'b11, 32'h310, 32'h314); step();
    chk("fill6_full", 64'(full), 64'd0);
    drive(2'b01, 32'h318, 32'h0);   step();
    chk("fill7_count", 64'(count), 64'd7);
    chk("fill7_full", 64'(full), 64'd1);
    drive(2'b11, 32'h320, 32'h324);
    step();
    chk("ovf_count", 64'(count), 64'd7);
    chk("ovf_error", 64'(error), 64'd1);
    chk("ovf_pc0", 64'(out_pc[31:0]), 64'h300);
    launch = 2'b11;
    step();
    chk("pop_count", 64'(count), 64'd5);
    chk("pop_full", 64'(full), 64'd0);
    chk("pop_error", 64'(error), 64'd1);
    chk("pop_pc0", 64'(out_pc[31:0]), 64'h308);
    chk("pop_pc1", 64'(out_pc[63:32]), 64'h30c);

    rst_pulse("rst1");

    // first edge after reset release accepts a write
    drive(2'b11, 32'h400, 32'h404);
    step();
    chk("postrst_count", 64'(count), 64'd2);
    chk("postrst_pc0", 64'(out_pc[31:0]), 64'h400);

    // steady stream wrapping the pointers several times
    nxt_pc = 32'h408;
    for (int i = 1; i <= 20; i++) begin
      drive(2'b11, nxt_pc, nxt_pc + 32'd4);
      launch = 2'b11;
      step();
      nxt_pc = nxt_pc + 32'd8;
      exp_pc = 32'h400 + 32'(8 * i);
      chk($sformatf("wrap%0d_pc0", i), 64'(out_pc[31:0]), 64'(exp_pc));
      chk($sformatf("wrap%0d_pc1", i), 64'(out_pc[63:32]), 64'(exp_pc + 32'd4));
      chk($sformatf("wrap%0d_count", i), 64'(count), 64'd2);
    end
    chk("wrap_error", 64'(error), 64'd0);

    // flush wins over same-cycle write and launch
    drive(2'b11, nxt_pc, nxt_pc + 32'd4); step();
    drive(2'b11, nxt_pc + 32'd8, nxt_pc + 32'd12); step();
    chk("pre_flush_count", 64'(count), 64'd6);
    flush = 1'b1;
    drive(2'b11, 32'hdead0, 32'hdead4);
    launch = 2'b11;
    step();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    drive(2'b11, 32'h500, 32'h504);
    step();
    chk("post_flush_count", 64'(count), 64'd2);
    chk("post_flush_pc0", 64'(out_pc[31:0]), 64'h500);
    chk("post_flush_pc1", 64'(out_pc[63:32]), 64'h504);

    // non-prefix launch is rejected
    drive(2'b01, 32'h508, 32'h0);
    step();
    chk("np_pre_count", 64'(count), 64'd3);
    launch = 2'b10;
    step();
    chk("np_error", 64'(error), 64'd1);
    chk("np_count", 64'(count), 64'd3);
    chk("np_pc0", 64'(out_pc[31:0]), 64'h500);

    rst_pulse("rst2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
